// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and the NOP word
package cpu_pkg;
    localparam int PC_WIDTH   = 64;
    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP = 32'h0;
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response bus
interface if_fetch_unit_if;
    import cpu_pkg::*;
    logic                  imemReq;
    logic [PC_WIDTH-1:0]   imemAddr;
    logic                  imemRvalid;
    logic [INST_WIDTH-1:0] imemRdata;
    modport master (output imemReq, imemAddr, input imemRvalid, imemRdata);
    modport slave  (input imemReq, imemAddr, output imemRvalid, imemRdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, one-outstanding imem handshake, IF/ID register with stall/redirect
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = 64'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branchTaken,
    input  logic [PC_WIDTH-1:0]    branchTarget,
    if_fetch_unit_if.master        imem,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INST_WIDTH-1:0]  inst,
    output logic                   hit
);
    state_t                state, state_nxt;
    logic [PC_WIDTH-1:0]   fetch_pc, fetch_nxt, tgt, tgt_nxt, pc_nxt;
    logic [INST_WIDTH-1:0] buf_inst, inst_nxt;
    logic                  hit_nxt, buf_ld, req;

    // fetch_pc is the in-flight address; a response cycle may already carry the next request
    assign imem.imemReq  = rst_n & req;
    assign imem.imemAddr = imem.imemRvalid ? fetch_nxt : fetch_pc;

    always_comb begin
        state_nxt = state;
        fetch_nxt = fetch_pc;
        tgt_nxt   = tgt;
        pc_nxt    = pc;
        inst_nxt  = inst;
        hit_nxt   = hit;
        buf_ld    = 1'b0;
        req       = 1'b0;
        case (state)
            S_REQ: begin
                req = 1'b1;
                if (imem.imemRvalid) begin
                    if (branchTaken) begin
                        fetch_nxt = branchTarget;
                        hit_nxt   = 1'b0;
                    end else if (stall) begin
                        buf_ld    = 1'b1;
                        req       = 1'b0;
                        state_nxt = S_HOLD;
                    end else begin
                        pc_nxt    = fetch_pc;
                        inst_nxt  = imem.imemRdata;
                        hit_nxt   = 1'b1;
                        fetch_nxt = fetch_pc + PC_STEP;
                    end
                end else if (branchTaken) begin
                    hit_nxt   = 1'b0;
                    tgt_nxt   = branchTarget;
                    state_nxt = S_DRAIN;
                end else if (!stall) begin
                    hit_nxt = 1'b0;
                end
            end
            S_DRAIN: begin
                req     = 1'b1;
                hit_nxt = 1'b0;
                tgt_nxt = branchTaken ? branchTarget : tgt;
                if (imem.imemRvalid) begin
                    fetch_nxt = tgt_nxt;
                    state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (branchTaken) begin
                    fetch_nxt = branchTarget;
                    hit_nxt   = 1'b0;
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    pc_nxt    = fetch_pc;
                    inst_nxt  = buf_inst;
                    hit_nxt   = 1'b1;
                    fetch_nxt = fetch_pc + PC_STEP;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            tgt      <= '0;
            buf_inst <= NOP;
            pc       <= '0;
            inst     <= NOP;
            hit      <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_nxt;
            tgt      <= tgt_nxt;
            buf_inst <= buf_ld ? imem.imemRdata : buf_inst;
            pc       <= pc_nxt;
            inst     <= inst_nxt;
            hit      <= hit_nxt;
        end
    end
endmodule
